load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute stage in the RV64 multicycle core.
- Takes one load or store request: a byte address (already computed as rs1+imm by the ALU), funct3, store data and rd.
- Performs the access against the 32-bit word-addressed unified memory, one or two beats per access.
- Returns sign/zero-extended 64-bit load data plus a writeback enable to the register-file writeback path.

Parameters:
- ADDR_W, 12, word-address width of the memory port (4096 x 32-bit words). Byte-address bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^(ADDR_W+2).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present from execute
- req_ready  out  1  unit idle, can accept; combinational, equals (state==IDLE)
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 of the LOAD/STORE instruction
- req_addr  in  64  byte address
- req_wdata  in  64  store data (rs2)
- req_rd  in  5  load destination register
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_rd  out  5  latched req_rd
- resp_wen  out  1  register writeback enable
- resp_err  out  1  misaligned address or illegal funct3
- mem_req  out  1  memory beat request
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  word address
- mem_wmask  out  4  byte-lane write enables
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid in the cycle mem_ack=1
- mem_ack  in  1  completes the current beat

Behaviour:
- States: IDLE, LO, HI, RESP.
- Reset (async, reset=0): state=IDLE immediately. All registered outputs are 0 (resp_*, mem_req, mem_we, mem_addr, mem_wmask, mem_wdata). req_ready=1.
- Reset mid-transaction: the beat is abandoned; mem_req drops in the same instant. Whether an in-flight write commits is the memory's responsibility. No resp_valid is produced.
- Accept: on req_valid && req_ready at a rising edge, latch all req_* fields. Requests while not IDLE are ignored, not queued.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Load 111 is illegal.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD. Store 1xx is illegal.
- Alignment rule: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
- Error path: misaligned or illegal request → IDLE→RESP directly with resp_err=1, resp_wen=0, resp_rdata=0. No mem_req is issued.
- IDLE→LO (legal request):
  - mem_req=1, mem_we=req_store, mem_addr=addr[ADDR_W+1:2].
  - SB: wdata={4{byte}}, wmask=0001<<addr[1:0].
  - SH: wdata={2{half}}, wmask=0011<<addr[1:0].
  - SW and SD low beat: wdata=wdata[31:0], wmask=1111.
  - Loads: wmask=0000.
- LO/HI: all mem_* outputs are held stable until mem_ack=1. Any number of wait cycles is allowed.
- LO + ack:
  - D access → HI. mem_req stays 1; mem_addr=(lo+1) mod 2^ADDR_W; SD wdata=wdata[63:32]. A load captures the low word.
  - Otherwise → RESP, with load data extracted from lane addr[1:0].
- HI + ack: capture the high word; → RESP.
- RESP:
  - mem_req=0, resp_valid=1 for exactly one cycle, then → IDLE.
  - resp_wen = load && !err && rd!=0.
- Load extension:
  - LB/LH/LW sign-extend from bit 7/15/31.
  - LBU/LHU/LWU zero-extend.
  - LD = {hi,lo}.
- Latency: with zero-wait ack, a single-beat access gives resp_valid 2 cycles after acceptance and a double access 3 cycles. The next request can be accepted the cycle after resp_valid.

Test Plan:
- LW addr 0x104, MEM[0x041]=0x80000001, ack same cycle → mem_addr=0x041, mem_we=0; resp_rdata=0xFFFFFFFF80000001, resp_wen=1, resp_rd=req_rd, resp_valid 2 cycles after accept.
- LB then LBU addr 0x103, MEM[0x040]=0xAB000000 → 0xFFFFFFFFFFFFFFAB, then 0x00000000000000AB; LB with rd=0 → resp_wen=0.
- SD addr 0x200, wdata 0x1122334455667788 → beat1 addr 0x080, wdata 0x55667788, mask 1111; beat2 addr 0x081, wdata 0x11223344; resp_valid 3 cycles after accept, resp_wen=0. Also SB addr 0x102, data 0xEF → mask 0100, wdata 0xEFEFEFEF.
- LH addr 0x101 and load funct3=111 → no mem_req; resp_err=1, resp_wen=0, resp_rdata=0, resp_valid the cycle after accept.
- mem_ack held low 3 cycles during LW → mem_addr/mem_req stable, req_ready=0, a concurrent req_valid is dropped; resp_valid follows the ack.
- Assert reset during the HI beat of LD → mem_req=0 and state IDLE without a clock edge, no resp_valid; req_ready=1 and a new LW completes normally after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request, response and memory-port bundle of the load/store unit.
// The slave modport is the unit itself; the master modport is the
// execute stage plus memory that surround it.
interface load_store_unit_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_wen;
  logic              resp_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_wen, resp_err,
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_wen, resp_err,
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store unit: one access at a time against a 32-bit word memory,
// one beat for B/H/W, two beats (low word then high word) for D.
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
  state_t state, state_nx;

  // latched request fields
  logic        op_store, op_store_nx;
  logic [2:0]  op_f3, op_f3_nx;
  logic [1:0]  op_off, op_off_nx;
  logic [4:0]  op_rd, op_rd_nx;
  logic [31:0] op_whi, op_whi_nx;
  logic [31:0] lo_word, lo_word_nx;

  logic              mem_req_nx, mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [3:0]        mem_wmask_nx;
  logic [31:0]       mem_wdata_nx;
  logic              resp_valid_nx, resp_wen_nx, resp_err_nx;
  logic [63:0]       resp_rdata_nx;
  logic [4:0]        resp_rd_nx;

  logic        legal, aligned, done;
  logic [31:0] lane;
  logic [63:0] ld_data;
  logic        unused_addr_bits;

  // byte-address bits above the memory window are ignored (address wraps)
  assign unused_addr_bits = ^bus.req_addr[63:ADDR_W+2];

  assign bus.req_ready = (state == IDLE);

  // funct3 legality and natural alignment of the incoming request
  always_comb begin
    legal = bus.req_store ? !bus.req_funct3[2] : (bus.req_funct3 != 3'b111);
    case (bus.req_funct3[1:0])
      2'b01:   aligned = !bus.req_addr[0];
      2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
      2'b11:   aligned = (bus.req_addr[2:0] == 3'b000);
      default: aligned = 1'b1;
    endcase
  end

  // pick the addressed lane of the returned word and extend it to 64 bits
  always_comb begin
    lane = bus.mem_rdata >> {op_off, 3'b000};
    case (op_f3)
      3'b000:  ld_data = {{56{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{48{lane[15]}}, lane[15:0]};
      3'b010:  ld_data = {{32{lane[31]}}, lane};
      3'b011:  ld_data = {bus.mem_rdata, lo_word};
      3'b100:  ld_data = {56'd0, lane[7:0]};
      3'b101:  ld_data = {48'd0, lane[15:0]};
      default: ld_data = {32'd0, lane};
    endcase
  end

  // next state plus next values of every registered output
  always_comb begin
    state_nx      = state;
    op_store_nx   = op_store;
    op_f3_nx      = op_f3;
    op_off_nx     = op_off;
    op_rd_nx      = op_rd;
    op_whi_nx     = op_whi;
    lo_word_nx    = lo_word;
    mem_req_nx    = bus.mem_req;
    mem_we_nx     = bus.mem_we;
    mem_addr_nx   = bus.mem_addr;
    mem_wmask_nx  = bus.mem_wmask;
    mem_wdata_nx  = bus.mem_wdata;
    resp_valid_nx = 1'b0;
    resp_rdata_nx = '0;
    resp_rd_nx    = '0;
    resp_wen_nx   = 1'b0;
    resp_err_nx   = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        op_store_nx = bus.req_store;
        op_f3_nx    = bus.req_funct3;
        op_off_nx   = bus.req_addr[1:0];
        op_rd_nx    = bus.req_rd;
        op_whi_nx   = bus.req_wdata[63:32];
        if (!(legal && aligned)) begin
          // bad request never touches memory
          state_nx      = RESP;
          resp_valid_nx = 1'b1;
          resp_err_nx   = 1'b1;
          resp_rd_nx    = bus.req_rd;
        end else begin
          state_nx     = LO;
          mem_req_nx   = 1'b1;
          mem_we_nx    = bus.req_store;
          mem_addr_nx  = bus.req_addr[ADDR_W+1:2];
          mem_wmask_nx = 4'b0000;
          mem_wdata_nx = '0;
          if (bus.req_store) begin
            case (bus.req_funct3[1:0])
              2'b00: begin
                mem_wdata_nx = {4{bus.req_wdata[7:0]}};
                mem_wmask_nx = 4'b0001 << bus.req_addr[1:0];
              end
              2'b01: begin
                mem_wdata_nx = {2{bus.req_wdata[15:0]}};
                mem_wmask_nx = 4'b0011 << bus.req_addr[1:0];
              end
              default: begin
                mem_wdata_nx = bus.req_wdata[31:0];
                mem_wmask_nx = 4'b1111;
              end
            endcase
          end
        end
      end
      LO: if (bus.mem_ack) begin
        if (op_f3[1:0] == 2'b11) begin
          // doubleword: keep the request up for the upper word
          state_nx     = HI;
          mem_addr_nx  = bus.mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          mem_wdata_nx = op_whi;
          lo_word_nx   = bus.mem_rdata;
        end else begin
          done = 1'b1;
        end
      end
      HI: if (bus.mem_ack) done = 1'b1;
      default: state_nx = IDLE;
    endcase
    if (done) begin
      state_nx      = RESP;
      mem_req_nx    = 1'b0;
      mem_we_nx     = 1'b0;
      mem_wmask_nx  = 4'b0000;
      resp_valid_nx = 1'b1;
      resp_rd_nx    = op_rd;
      resp_wen_nx   = !op_store && (op_rd != 5'd0);
      resp_rdata_nx = op_store ? 64'd0 : ld_data;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // latched request and registered outputs; reset drops mem_req at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_store       <= 1'b0;
      op_f3          <= '0;
      op_off         <= '0;
      op_rd          <= '0;
      op_whi         <= '0;
      lo_word        <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wmask  <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_rd    <= '0;
      bus.resp_wen   <= 1'b0;
      bus.resp_err   <= 1'b0;
    end else begin
      op_store       <= op_store_nx;
      op_f3          <= op_f3_nx;
      op_off         <= op_off_nx;
      op_rd          <= op_rd_nx;
      op_whi         <= op_whi_nx;
      lo_word        <= lo_word_nx;
      bus.mem_req    <= mem_req_nx;
      bus.mem_we     <= mem_we_nx;
      bus.mem_addr   <= mem_addr_nx;
      bus.mem_wmask  <= mem_wmask_nx;
      bus.mem_wdata  <= mem_wdata_nx;
      bus.resp_valid <= resp_valid_nx;
      bus.resp_rdata <= resp_rdata_nx;
      bus.resp_rd    <= resp_rd_nx;
      bus.resp_wen   <= resp_wen_nx;
      bus.resp_err   <= resp_err_nx;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory, response and
// beat scoreboards, a wait-state memory responder and directed plus random ops.
module tb_load_store_unit;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(AW)) bus();
  load_store_unit #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct { logic [AW-1:0] addr; logic we; logic [3:0] mask; logic [31:0] wdata; logic chk_data; } beat_t;
  typedef struct { int acc; logic err; logic wen; logic [4:0] rd; logic [63:0] rdata; } resp_t;

  int errors = 0, checks = 0;
  int cyc = 0;
  int stall_until = -1;
  bit noack = 1'b0, rand_ack = 1'b0;

  logic [31:0] mem [4096];       // memory seen by the DUT
  logic [7:0]  ref_mem [16384];  // byte-level reference image
  beat_t beat_q[$];
  resp_t exp_q[$];

  int last_acc, last_resp_cyc, last_ack_cyc, beat_idx, last_nbeats;
  logic [63:0] last_rdata;
  logic [4:0]  last_rd;
  logic        last_wen, last_err;
  logic [AW-1:0] lg_addr [2];
  logic [31:0]   lg_wdata [2];
  logic [3:0]    lg_mask [2];
  logic          lg_we [2];
  bit prev_wait = 1'b0;
  logic [AW-1:0] p_addr;
  logic [31:0]   p_wdata;
  logic [3:0]    p_mask;
  logic          p_we;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) ref_mem[w*4+i] = v[8*i +: 8];
  endtask

  // expected outcome of one request, from the ISA rules on a byte memory
  task automatic model(input bit st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [4:0] rd);
    resp_t e;
    beat_t b;
    int size, base;
    logic [63:0] v;
    size = 1 << f3[1:0];
    base = int'(a[13:0]);
    e.acc = cyc;
    e.rd = rd;
    e.err = (st ? f3[2] : (f3 == 3'b111)) || ((int'(a[2:0]) % size) != 0);
    e.wen = !st && !e.err && (rd != 5'd0);
    e.rdata = '0;
    if (!e.err) begin
      if (st) begin
        for (int i = 0; i < size; i++) ref_mem[(base+i) % 16384] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[(base+i) % 16384];
        if (!f3[2] && size < 8 && v[8*size-1])
          for (int i = size*8; i < 64; i++) v[i] = 1'b1;
        e.rdata = v;
      end
      for (int k = 0; k < (size == 8 ? 2 : 1); k++) begin
        b.addr = AW'((base >> 2) + k);
        b.we = st;
        b.chk_data = st;
        b.mask = !st ? 4'h0 : (size >= 4) ? 4'hF : 4'(((1 << size) - 1) << (base % 4));
        case (size)
          1:       b.wdata = {4{wd[7:0]}};
          2:       b.wdata = {2{wd[15:0]}};
          4:       b.wdata = wd[31:0];
          default: b.wdata = (k == 1) ? wd[63:32] : wd[31:0];
        endcase
        beat_q.push_back(b);
      end
    end
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // memory responder: commit writes on the ack edge, then decide the next ack
  always @(posedge clk) begin
    if (reset && bus.mem_req && bus.mem_ack && bus.mem_we)
      for (int i = 0; i < 4; i++)
        if (bus.mem_wmask[i]) mem[bus.mem_addr][8*i +: 8] = bus.mem_wdata[8*i +: 8];
    #1;
    if (bus.mem_req && !noack && cyc > stall_until)
      bus.mem_ack = rand_ack ? ($urandom_range(0, 2) != 0) : 1'b1;
    else
      bus.mem_ack = 1'b0;
    bus.mem_rdata = bus.mem_req ? mem[bus.mem_addr] : $urandom;
  end

  // per-cycle compare against the scoreboards
  always @(negedge clk) begin
    beat_t b;
    resp_t e;
    if (!reset) begin
      prev_wait = 1'b0;
      beat_idx = 0;
    end else begin
      if (bus.mem_req) begin
        chk("ready_while_busy", 64'(bus.req_ready), 64'd0);
        if (prev_wait) begin
          chk("hold_addr", 64'(bus.mem_addr), 64'(p_addr));
          chk("hold_we", 64'(bus.mem_we), 64'(p_we));
          chk("hold_mask", 64'(bus.mem_wmask), 64'(p_mask));
          chk("hold_wdata", 64'(bus.mem_wdata), 64'(p_wdata));
        end
        if (bus.mem_ack) begin
          if (beat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: beat at addr %h, required none", bus.mem_addr);
          end else begin
            b = beat_q.pop_front();
            chk("beat_addr", 64'(bus.mem_addr), 64'(b.addr));
            chk("beat_we", 64'(bus.mem_we), 64'(b.we));
            chk("beat_mask", 64'(bus.mem_wmask), 64'(b.mask));
            if (b.chk_data) chk("beat_wdata", 64'(bus.mem_wdata), 64'(b.wdata));
          end
          if (beat_idx < 2) begin
            lg_addr[beat_idx] = bus.mem_addr;
            lg_wdata[beat_idx] = bus.mem_wdata;
            lg_mask[beat_idx] = bus.mem_wmask;
            lg_we[beat_idx] = bus.mem_we;
          end
          beat_idx++;
          last_ack_cyc = cyc;
        end
        prev_wait = !bus.mem_ack;
        p_addr = bus.mem_addr; p_we = bus.mem_we; p_mask = bus.mem_wmask; p_wdata = bus.mem_wdata;
      end else begin
        prev_wait = 1'b0;
      end
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: resp_valid=1, required 0");
        end else begin
          e = exp_q.pop_front();
          chk("resp_rd", 64'(bus.resp_rd), 64'(e.rd));
          chk("resp_err", 64'(bus.resp_err), 64'(e.err));
          chk("resp_wen", 64'(bus.resp_wen), 64'(e.wen));
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("beats_left", 64'(beat_q.size()), 64'd0);
          chk("resp_timing", 64'(cyc), 64'(e.err ? e.acc + 1 : last_ack_cyc + 1));
        end
        last_rdata = bus.resp_rdata; last_rd = bus.resp_rd;
        last_wen = bus.resp_wen; last_err = bus.resp_err;
        last_resp_cyc = cyc; last_nbeats = beat_idx; beat_idx = 0;
      end
    end
  end

  task automatic issue(input bit st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [4:0] rd, input int stall);
    int n = 0;
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: req_ready=%0b, required 1", bus.req_ready);
    end else begin
      bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
      bus.req_addr = a; bus.req_wdata = wd; bus.req_rd = rd;
      last_acc = cyc;
      stall_until = cyc + stall;
      model(st, f3, a, wd, rd);
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete(); beat_q.delete();
    end
  endtask

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [4:0] rd);
    issue(st, f3, a, wd, rd, 0);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    for (int w = 0; w < 4096; w++) set_word(w, $urandom);

    #12;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wmask", 64'(bus.mem_wmask), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk);

    // LW with sign bit set
    set_word(12'h041, 32'h80000001);
    do_op(0, 3'b010, 64'h104, 64'd0, 5'd5);
    chk("lw_rdata", last_rdata, 64'hFFFFFFFF80000001);
    chk("lw_wen", 64'(last_wen), 64'd1);
    chk("lw_rd", 64'(last_rd), 64'd5);
    chk("lw_latency", 64'(last_resp_cyc - last_acc), 64'd2);
    chk("lw_addr", 64'(lg_addr[0]), 64'h041);
    chk("lw_we", 64'(lg_we[0]), 64'd0);

    // LB / LBU from lane 3, LB to x0
    set_word(12'h040, 32'hAB000000);
    do_op(0, 3'b000, 64'h103, 64'd0, 5'd3);
    chk("lb_rdata", last_rdata, 64'hFFFFFFFFFFFFFFAB);
    do_op(0, 3'b100, 64'h103, 64'd0, 5'd3);
    chk("lbu_rdata", last_rdata, 64'h00000000000000AB);
    do_op(0, 3'b000, 64'h103, 64'd0, 5'd0);
    chk("lb_x0_wen", 64'(last_wen), 64'd0);

    // SD two beats, then read back with LD
    do_op(1, 3'b011, 64'h200, 64'h1122334455667788, 5'd1);
    chk("sd_beats", 64'(last_nbeats), 64'd2);
    chk("sd_addr0", 64'(lg_addr[0]), 64'h080);
    chk("sd_wdata0", 64'(lg_wdata[0]), 64'h55667788);
    chk("sd_mask0", 64'(lg_mask[0]), 64'hF);
    chk("sd_addr1", 64'(lg_addr[1]), 64'h081);
    chk("sd_wdata1", 64'(lg_wdata[1]), 64'h11223344);
    chk("sd_latency", 64'(last_resp_cyc - last_acc), 64'd3);
    chk("sd_wen", 64'(last_wen), 64'd0);
    do_op(0, 3'b011, 64'h200, 64'd0, 5'd8);
    chk("ld_rdata", last_rdata, 64'h1122334455667788);

    // SB lane 2
    do_op(1, 3'b000, 64'h102, 64'hEF, 5'd0);
    chk("sb_mask", 64'(lg_mask[0]), 64'h4);
    chk("sb_wdata", 64'(lg_wdata[0]), 64'hEFEFEFEF);

    // misaligned LH and illegal load funct3
    do_op(0, 3'b001, 64'h101, 64'd0, 5'd4);
    chk("lh_mis_err", 64'(last_err), 64'd1);
    chk("lh_mis_rdata", last_rdata, 64'd0);
    chk("lh_mis_beats", 64'(last_nbeats), 64'd0);
    chk("lh_mis_latency", 64'(last_resp_cyc - last_acc), 64'd1);
    do_op(0, 3'b111, 64'h100, 64'd0, 5'd4);
    chk("ld111_err", 64'(last_err), 64'd1);
    chk("ld111_wen", 64'(last_wen), 64'd0);

    // three wait cycles, with a request offered while busy
    issue(0, 3'b010, 64'h104, 64'd0, 5'd7, 3);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 64'h104; bus.req_wdata = 64'h0BADBADB; bus.req_rd = 5'd2;
    chk("busy_ready0", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("busy_ready1", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_done();
    chk("stall_latency", 64'(last_resp_cyc - last_acc), 64'd5);
    chk("stall_rdata", last_rdata, 64'hFFFFFFFF80000001);

    // reset during the upper beat of an LD
    issue(0, 3'b011, 64'h300, 64'd0, 5'd9, 0);
    noack = 1'b1;
    @(negedge clk);
    chk("hi_req", 64'(bus.mem_req), 64'd1);
    chk("hi_addr", 64'(bus.mem_addr), 64'h0C1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    exp_q.delete(); beat_q.delete();
    noack = 1'b0;
    @(negedge clk);
    chk("rst_mid_resp", 64'(bus.resp_valid), 64'd0);
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk);
    do_op(0, 3'b010, 64'h104, 64'd0, 5'd6);
    chk("post_rst_rdata", last_rdata, 64'hFFFFFFFF80000001);
    chk("post_rst_latency", 64'(last_resp_cyc - last_acc), 64'd2);

    // randomized traffic with random wait states
    rand_ack = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[13:3] = 11'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
            {$urandom, $urandom}, 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
